// File: rtl/tdm_pkg.sv
// Shared definitions for the 1-to-4 TDM demultiplexer: slot count and FSM
// state encoding. Build option TDM_DEMUX_PARITY_EN adds the PAR state that
// receives the trailing even-parity sample.
package tdm_pkg;

   localparam int NUM_SLOTS = 4;

`ifdef TDM_DEMUX_PARITY_EN
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_S1   = 3'd1,
      ST_S2   = 3'd2,
      ST_S3   = 3'd3,
      ST_PAR  = 3'd4
   } tdm_state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_S1   = 2'd1,
      ST_S2   = 2'd2,
      ST_S3   = 2'd3
   } tdm_state_t;
`endif

endpackage

// File: rtl/tdm_parity_chk.sv
// Even-parity check over a flattened frame. Only instantiated when the
// demultiplexer is built with TDM_DEMUX_PARITY_EN.
module tdm_parity_chk #(
   parameter int DATA_W = 4
) (
   input  logic [DATA_W-1:0] data,
   input  logic              par_bit,
   output logic              err
);

   // With even parity the transmitted bit equals the XOR of all data bits.
   assign err = (^data) ^ par_bit;

endmodule

// File: rtl/tdm_demux_1x4.sv
// 1-to-4 TDM demultiplexer. Samples are accepted on en=1; frame_start marks
// slot 0 and aborts any partial frame. The four slot outputs update together
// only when a frame completes, with a one-cycle frame_valid pulse.
// Build option TDM_DEMUX_PARITY_EN appends one parity sample per frame
// (din[0] = even parity over all data bits) and drives parity_err.
module tdm_demux_1x4
   import tdm_pkg::*;
#(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] din,
   input  logic         en,
   input  logic         frame_start,
   output logic [W-1:0] y0,
   output logic [W-1:0] y1,
   output logic [W-1:0] y2,
   output logic [W-1:0] y3,
   output logic         frame_valid,
   output logic [1:0]   slot,
   output logic         busy,
   output logic         parity_err
);

`ifdef TDM_DEMUX_PARITY_EN
   // Slot 3 must be held too, because completion happens on the parity sample.
   localparam int SHADOW_N = NUM_SLOTS;
`else
   // Slot 3 is taken straight from din on the completing sample.
   localparam int SHADOW_N = NUM_SLOTS - 1;
`endif

   tdm_state_t   state_reg;
   tdm_state_t   state_next;

   logic [W-1:0] shadow_reg [SHADOW_N];
   logic [W-1:0] y_reg      [NUM_SLOTS];
   logic [W-1:0] frame_data [NUM_SLOTS];
   logic         frame_valid_reg;

   logic         cap_en;
   logic [1:0]   cap_idx;
   logic         frame_done;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next state, shadow capture select and frame completion. frame_start
   // has priority over normal slot advance so a restart always wins.
   always_comb begin
      state_next = state_reg;
      cap_en     = 1'b0;
      cap_idx    = 2'd0;
      frame_done = 1'b0;
      if (en) begin
         if (frame_start) begin
            state_next = ST_S1;
            cap_en     = 1'b1;
            cap_idx    = 2'd0;
         end else begin
            case (state_reg)
               ST_IDLE: begin
                  state_next = ST_IDLE;
               end
               ST_S1: begin
                  state_next = ST_S2;
                  cap_en     = 1'b1;
                  cap_idx    = 2'd1;
               end
               ST_S2: begin
                  state_next = ST_S3;
                  cap_en     = 1'b1;
                  cap_idx    = 2'd2;
               end
`ifdef TDM_DEMUX_PARITY_EN
               ST_S3: begin
                  state_next = ST_PAR;
                  cap_en     = 1'b1;
                  cap_idx    = 2'd3;
               end
               ST_PAR: begin
                  state_next = ST_IDLE;
                  frame_done = 1'b1;
               end
`else
               ST_S3: begin
                  state_next = ST_IDLE;
                  frame_done = 1'b1;
               end
`endif
               default: begin
                  state_next = ST_IDLE;
               end
            endcase
         end
      end
   end

   // Status outputs decoded from the current state.
   always_comb begin
      slot = 2'd0;
      busy = 1'b1;
      case (state_reg)
         ST_IDLE: begin
            slot = 2'd0;
            busy = 1'b0;
         end
         ST_S1:   slot = 2'd1;
         ST_S2:   slot = 2'd2;
         ST_S3:   slot = 2'd3;
`ifdef TDM_DEMUX_PARITY_EN
         ST_PAR:  slot = 2'd3;
`endif
         default: begin
            slot = 2'd0;
            busy = 1'b0;
         end
      endcase
   end

   // Shadow registers hold the partial frame until it completes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SHADOW_N; i++) begin
            shadow_reg[i] <= '0;
         end
      end else if (cap_en) begin
         shadow_reg[cap_idx] <= din;
      end
   end

   // Assemble the completed frame from shadow storage (and din for the
   // last data slot when there is no parity sample).
   generate
      for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_frame
         if (gi < SHADOW_N) begin : g_shadow
            assign frame_data[gi] = shadow_reg[gi];
         end else begin : g_live
            assign frame_data[gi] = din;
         end
      end
   endgenerate

   // Output registers load only on completion; frame_valid follows them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            y_reg[i] <= '0;
         end
         frame_valid_reg <= 1'b0;
      end else begin
         frame_valid_reg <= frame_done;
         if (frame_done) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
               y_reg[i] <= frame_data[i];
            end
         end
      end
   end

   assign y0          = y_reg[0];
   assign y1          = y_reg[1];
   assign y2          = y_reg[2];
   assign y3          = y_reg[3];
   assign frame_valid = frame_valid_reg;

`ifdef TDM_DEMUX_PARITY_EN
   logic [NUM_SLOTS*W-1:0] frame_flat;
   logic                   frame_err;
   logic                   parity_err_reg;

   generate
      for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_flat
         assign frame_flat[gi*W +: W] = frame_data[gi];
      end
   endgenerate

   tdm_parity_chk #(
      .DATA_W (NUM_SLOTS * W)
   ) u_parity_chk (
      .data    (frame_flat),
      .par_bit (din[0]),
      .err     (frame_err)
   );

   // Parity error is a pulse aligned with frame_valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         parity_err_reg <= 1'b0;
      end else begin
         parity_err_reg <= frame_done & frame_err;
      end
   end

   assign parity_err = parity_err_reg;
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux_1x4.sv
// Self-checking bench for tdm_demux_1x4. A queue-based frame model is checked
// against the DUT on every falling edge; directed literal checks pin the model.
// Honours TDM_DEMUX_PARITY_EN (5-sample frames with trailing parity bit).
module tb_tdm_demux_1x4;

   localparam int W = 1;
`ifdef TDM_DEMUX_PARITY_EN
   localparam int FRAME_LEN = 5;
`else
   localparam int FRAME_LEN = 4;
`endif

   logic         clk;
   logic         rst;
   logic [W-1:0] din;
   logic         en;
   logic         frame_start;
   logic [W-1:0] y0, y1, y2, y3;
   logic         frame_valid;
   logic [1:0]   slot;
   logic         busy;
   logic         parity_err;

   int pass_cnt = 0;
   int chk_cnt  = 0;
   int fv_cnt   = 0;

   tdm_demux_1x4 #(.W(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .din         (din),
      .en          (en),
      .frame_start (frame_start),
      .y0          (y0),
      .y1          (y1),
      .y2          (y2),
      .y3          (y3),
      .frame_valid (frame_valid),
      .slot        (slot),
      .busy        (busy),
      .parity_err  (parity_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [W-1:0] q[$];
   logic [W-1:0] exp_y [4];
   logic         exp_fv;
   logic         exp_pe;

   initial begin
      for (int i = 0; i < 4; i++) exp_y[i] = '0;
      exp_fv = 1'b0;
      exp_pe = 1'b0;
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q.delete();
         for (int i = 0; i < 4; i++) exp_y[i] = '0;
         exp_fv = 1'b0;
         exp_pe = 1'b0;
      end else begin
         exp_fv = 1'b0;
         exp_pe = 1'b0;
         if (en) begin
            if (frame_start) begin
               q.delete();
               q.push_back(din);
            end else if (q.size() != 0) begin
               q.push_back(din);
               if (q.size() == FRAME_LEN) begin
                  int ones;
                  ones = 0;
                  for (int i = 0; i < 4; i++) begin
                     exp_y[i] = q[i];
                     ones += $countones(q[i]);
                  end
`ifdef TDM_DEMUX_PARITY_EN
                  exp_pe = ((ones % 2) == 1) != q[4][0];
`endif
                  exp_fv = 1'b1;
                  q.delete();
               end
            end
         end
      end
   end

   // Compare process: DUT versus model on every falling edge.
   always @(negedge clk) begin
      int exp_slot;
      exp_slot = (q.size() > 3) ? 3 : q.size();
      chk("y0", 32'(y0), 32'(exp_y[0]));
      chk("y1", 32'(y1), 32'(exp_y[1]));
      chk("y2", 32'(y2), 32'(exp_y[2]));
      chk("y3", 32'(y3), 32'(exp_y[3]));
      chk("frame_valid", 32'(frame_valid), 32'(exp_fv));
      chk("parity_err", 32'(parity_err), 32'(exp_pe));
      chk("slot", 32'(slot), 32'(exp_slot));
      chk("busy", 32'(busy), 32'(q.size() != 0));
      if (frame_valid === 1'b1) fv_cnt++;
   end

   // ---------------- stimulus ----------------
   task automatic send(input logic [W-1:0] d, input logic fs);
      en          = 1'b1;
      din         = d;
      frame_start = fs;
      @(posedge clk);
      #1;
      en          = 1'b0;
      frame_start = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Data bits a,b,c,d plus, in the parity build, parity bit p.
   task automatic frame4(input logic [3:0] bits, input logic p);
      send(W'(bits[3]), 1'b1);
      send(W'(bits[2]), 1'b0);
      send(W'(bits[1]), 1'b0);
      send(W'(bits[0]), 1'b0);
`ifdef TDM_DEMUX_PARITY_EN
      send(W'(p), 1'b0);
`else
      if (p) begin end
`endif
   endtask

   function automatic logic [3:0] ybus();
      return {y0[0], y1[0], y2[0], y3[0]};
   endfunction

   initial begin
      int fv0;
      rst         = 1'b1;
      en          = 1'b0;
      din         = '0;
      frame_start = 1'b0;
      idle(2);
      chk("reset_y", 32'(ybus()), 32'h0);
      chk("reset_slot", 32'(slot), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_fv", 32'(frame_valid), 32'd0);
      rst = 1'b0;
      idle(2);

      // Basic frame 1,0,1,1; parity bit 1 is correct.
      send(1'b1, 1'b0);           // ignored: no frame_start in IDLE
      chk("idle_ignore_busy", 32'(busy), 32'd0);
      frame4(4'b1011, 1'b1);
      chk("f1_y", 32'(ybus()), 32'hB);
      chk("f1_fv", 32'(frame_valid), 32'd1);
      chk("f1_pe", 32'(parity_err), 32'd0);
      idle(1);
      chk("f1_fv_drop", 32'(frame_valid), 32'd0);

      // Same frame with a 3-cycle stall between slots 1 and 2.
      idle(2);
      send(1'b1, 1'b1);
      send(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         idle(1);
         chk("stall_slot", 32'(slot), 32'd2);
         chk("stall_busy", 32'(busy), 32'd1);
      end
      send(1'b1, 1'b0);
      send(1'b1, 1'b0);
`ifdef TDM_DEMUX_PARITY_EN
      send(1'b1, 1'b0);
`endif
      chk("stall_y", 32'(ybus()), 32'hB);
      chk("stall_fv", 32'(frame_valid), 32'd1);

      // Abort after two slots, then 1,1,0,0.
      idle(2);
      fv0 = fv_cnt;
      send(1'b0, 1'b1);
      send(1'b1, 1'b0);
      frame4(4'b1100, 1'b0);
      chk("abort_y", 32'(ybus()), 32'hC);
      idle(2);
      chk("abort_pulses", 32'(fv_cnt - fv0), 32'd1);

      // Asynchronous reset mid-frame.
      send(1'b1, 1'b1);
      send(1'b1, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_y", 32'(ybus()), 32'h0);
      chk("arst_slot", 32'(slot), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_fv", 32'(frame_valid), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      fv0 = fv_cnt;
      idle(2);
      chk("arst_no_fv", 32'(fv_cnt - fv0), 32'd0);
      frame4(4'b0101, 1'b0);
      chk("arst_frame_y", 32'(ybus()), 32'h5);

      // Back-to-back frames with no idle cycle.
      idle(2);
      fv0 = fv_cnt;
      frame4(4'b1011, 1'b1);
      frame4(4'b0110, 1'b0);
      chk("b2b_y", 32'(ybus()), 32'h6);
      idle(2);
      chk("b2b_pulses", 32'(fv_cnt - fv0), 32'd2);

`ifdef TDM_DEMUX_PARITY_EN
      // Wrong parity bit.
      frame4(4'b1011, 1'b0);
      chk("perr_fv", 32'(frame_valid), 32'd1);
      chk("perr_pe", 32'(parity_err), 32'd1);
      idle(1);
      chk("perr_drop", 32'(parity_err), 32'd0);
`endif

      idle(3);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/tdm_demux_1x4.md
TDM_DEMUX_1X4 -- requirements
Module: tdm_demux_1x4

Interface
REQ-001 SHALL have parameter W, default 1: width in bits of each slot sample on din and y0..y3.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port din, input, W: serial TDM sample; one slot per accepted cycle.
REQ-005 SHALL have port en, input, 1: sample strobe; din is accepted only on cycles where en=1.
REQ-006 SHALL have port frame_start, input, 1: qualified by en; marks din as the slot-0 sample.
REQ-007 SHALL have ports y0, y1, y2, y3, output, W each: demultiplexed slot 0..3 values of the last complete frame.
REQ-008 SHALL have port frame_valid, output, 1: one-cycle pulse when y0..y3 update.
REQ-009 SHALL have port slot, output, 2: index of the next expected slot (0 in IDLE).
REQ-010 SHALL have port busy, output, 1: high while a frame is partially received.
REQ-011 SHALL have port parity_err, output, 1: frame parity mismatch flag, valid with frame_valid.

Function
REQ-012 SHALL implement states IDLE, S1, S2, S3, plus PAR only when parity is compiled in.
REQ-013 SHALL, in IDLE, on en=1 and frame_start=1, capture din into shadow slot 0 and move to S1; en=1 without frame_start is ignored.
REQ-014 SHALL, in S1/S2, on en=1, capture din into shadow slot 1/2 and advance to S2/S3.
REQ-015 SHALL, in S3, on en=1, complete the frame: load y0..y3 from shadow 0..2 and din together, return to IDLE, and pulse frame_valid in the cycle after that edge (aligned with new y).
REQ-016 SHALL hold state, shadow and outputs on any cycle with en=0 (stall, unlimited length).
REQ-017 SHALL, on en=1 and frame_start=1 in any non-IDLE state, abort the partial frame, capture din as slot 0, go to S1, and pulse no frame_valid.
REQ-018 SHALL leave y0..y3 unchanged except at frame completion; aborted frames never reach the outputs.
REQ-019 SHALL drive slot = 0/1/2/3 in IDLE/S1/S2/S3, and 3 in PAR.
REQ-020 SHALL drive busy = 1 in every state except IDLE.
REQ-021 SHALL support back-to-back frames: frame_start accepted on the cycle frame_valid is high.

Reset
REQ-022 SHALL, while rst=1, force state IDLE, shadow registers 0, y0..y3 0, frame_valid 0, parity_err 0, slot 0, busy 0, regardless of clk.
REQ-023 SHALL, on reset asserted mid-frame, discard the partial frame, with no frame_valid after release.

Configuration
REQ-024 SHALL use macro TDM_DEMUX_PARITY_EN to compile the parity slot in or out.
REQ-025 SHALL, with TDM_DEMUX_PARITY_EN defined, enter PAR after the S3 sample instead of completing; the next en=1 sample's din[0] is the even-parity bit over all 4W data bits; completion per REQ-015 occurs on that PAR sample; parity_err = mismatch, pulsed with frame_valid.
REQ-026 SHALL, with TDM_DEMUX_PARITY_EN undefined, have no PAR state, 4-sample frames, and parity_err tied 0.

Structure
REQ-027 SHALL take state encoding and NUM_SLOTS=4 from shared package tdm_pkg.
REQ-028 SHALL place the parity reduction in sub-module tdm_parity_chk, instantiated only under TDM_DEMUX_PARITY_EN.

Verification
REQ-029 Frame 1,0,1,1 (en=1, frame_start on first) -> next cycle y0..y3=1,0,1,1, frame_valid=1 for exactly one cycle.
REQ-030 Same frame with en=0 for 3 cycles between slots 1 and 2 -> identical result, slot held at 2 during stall, busy=1.
REQ-031 frame_start after 2 slots, then 1,1,0,0 -> y=1,1,0,0, only one frame_valid pulse.
REQ-032 rst=1 asynchronously after slot 1, released, then frame 0,1,0,1 -> all outputs 0 immediately, then y=0,1,0,1.
REQ-033 Two back-to-back frames 1,0,1,1 then 0,1,1,0, no idle cycle -> two frame_valid pulses, y ends 0,1,1,0.
REQ-034 With TDM_DEMUX_PARITY_EN, frame 1,0,1,1 with parity bit 1 -> parity_err=0; with parity bit 0 -> parity_err=1 with frame_valid.
